// File: rtl/key_map_player.sv
// key_map_player: consumer side of the custom key-mapping flow.
// A candidate permutation is captured from the settings page and checked
// over eight cycles, one entry per cycle. Only a legal permutation replaces
// the active map. Live physical button levels are translated through the
// active map into logical notes, then debounced, for the tone/VGA datapath.
module key_map_player #(
    parameter int MIN_HOLD = 2
) (
    input  logic       slow_clk,
    input  logic       rst_n,
    input  logic [2:0] perm0,
    input  logic [2:0] perm1,
    input  logic [2:0] perm2,
    input  logic [2:0] perm3,
    input  logic [2:0] perm4,
    input  logic [2:0] perm5,
    input  logic [2:0] perm6,
    input  logic [2:0] perm7,
    input  logic       perm_load,
    input  logic       map_reset,
    input  logic [7:0] buts,
    output logic [7:0] note_onehot,
    output logic [2:0] note,
    output logic       note_valid,
    output logic       note_press,
    output logic       map_busy,
    output logic       map_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    // Debounce threshold as a counter-width value; MIN_HOLD is limited to 1..7.
    localparam logic [2:0] HOLD_MAX = 3'(MIN_HOLD);

    // Identity map: note N is played by physical button N.
    localparam logic [7:0][2:0] IDENT_MAP = {3'd7, 3'd6, 3'd5, 3'd4,
                                             3'd3, 3'd2, 3'd1, 3'd0};

    // One-hot decode of a 3-bit index.
    function automatic logic [7:0] onehot8(input logic [2:0] i);
        return 8'd1 << i;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Map-validation state
    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       seen_q, seen_d;
    logic             dup_q, dup_d;
    logic [7:0][2:0]  shadow_q, shadow_d;
    logic [7:0][2:0]  amap_q, amap_d;
    logic             map_err_q, map_err_d;
    logic             map_busy_q, map_busy_d;

    // Note-path state
    logic [7:0]       onehot_q, onehot_d;
    logic [2:0]       hold_q, hold_d;
    logic             valid_q, valid_d;
    logic [2:0]       note_q, note_d;
    logic             press_q, press_d;

    logic [7:0][2:0]  perm_vec_s;
    logic [2:0]       cur_s;
    logic             dup_now_s;

    assign perm_vec_s = {perm7, perm6, perm5, perm4, perm3, perm2, perm1, perm0};

    // Validation FSM next state: capture on load, walk the snapshot, commit or reject.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seen_d    = seen_q;
        dup_d     = dup_q;
        shadow_d  = shadow_q;
        amap_d    = amap_q;
        map_err_d = map_err_q;
        cur_s     = shadow_q[idx_q];
        dup_now_s = dup_q | seen_q[cur_s];

        if (map_reset) begin
            // Restore identity and abandon any validation in flight.
            state_d   = ST_IDLE;
            amap_d    = IDENT_MAP;
            map_err_d = 1'b0;
            idx_d     = 3'd0;
            seen_d    = 8'h00;
            dup_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (perm_load) begin
                        shadow_d = perm_vec_s;
                        idx_d    = 3'd0;
                        seen_d   = 8'h00;
                        dup_d    = 1'b0;
                        state_d  = ST_CHECK;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    // A later perm_load is deliberately ignored here.
                    seen_d = seen_q | onehot8(cur_s);
                    dup_d  = dup_now_s;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_IDLE;
                        if (dup_now_s) begin
                            map_err_d = 1'b1;
                        end else begin
                            amap_d    = shadow_q;
                            map_err_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        map_busy_d = (state_d == ST_CHECK);
    end

    // Note path next state: remap buttons through the active map and debounce.
    always_comb begin
        onehot_d = 8'h00;
        for (int n = 0; n < 8; n++) begin
            onehot_d[n] = buts[amap_q[n]];
        end

        if (onehot_d == onehot_q) begin
            if (hold_q >= HOLD_MAX) begin
                hold_d = HOLD_MAX;
            end else begin
                hold_d = hold_q + 3'd1;
            end
        end else begin
            hold_d = 3'd0;
        end

        valid_d = (hold_d >= HOLD_MAX) && (onehot_d != 8'h00);

        if (valid_d) begin
            note_d = lowest_idx(onehot_d);
        end else begin
            note_d = note_q;
        end

        press_d = valid_d && (!valid_q || (note_d != note_q));
    end

    // Validation state registers.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            seen_q     <= 8'h00;
            dup_q      <= 1'b0;
            shadow_q   <= '0;
            amap_q     <= IDENT_MAP;
            map_err_q  <= 1'b0;
            map_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seen_q     <= seen_d;
            dup_q      <= dup_d;
            shadow_q   <= shadow_d;
            amap_q     <= amap_d;
            map_err_q  <= map_err_d;
            map_busy_q <= map_busy_d;
        end
    end

    // Note path registers.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_q <= 8'h00;
            hold_q   <= 3'd0;
            valid_q  <= 1'b0;
            note_q   <= 3'd0;
            press_q  <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            note_q   <= note_d;
            press_q  <= press_d;
        end
    end

    assign note_onehot = onehot_q;
    assign note        = note_q;
    assign note_valid  = valid_q;
    assign note_press  = press_q;
    assign map_busy    = map_busy_q;
    assign map_err     = map_err_q;

endmodule

// File: tb/tb_key_map_player.sv
// Bench for key_map_player: a fixed vector table for the debounce path,
// directed sequences for the map-load corner cases, then random stimulus,
// with every cycle also compared against a behavioural model.
module tb_key_map_player;

    localparam int MIN_HOLD = 2;

    logic       slow_clk;
    logic       rst_n;
    logic [2:0] perm [8];
    logic       perm_load;
    logic       map_reset;
    logic [7:0] buts;
    logic [7:0] note_onehot;
    logic [2:0] note;
    logic       note_valid;
    logic       note_press;
    logic       map_busy;
    logic       map_err;

    int n_checks = 0;
    int n_fail   = 0;

    key_map_player #(.MIN_HOLD(MIN_HOLD)) dut (
        .slow_clk    (slow_clk),
        .rst_n       (rst_n),
        .perm0       (perm[0]),
        .perm1       (perm[1]),
        .perm2       (perm[2]),
        .perm3       (perm[3]),
        .perm4       (perm[4]),
        .perm5       (perm[5]),
        .perm6       (perm[6]),
        .perm7       (perm[7]),
        .perm_load   (perm_load),
        .map_reset   (map_reset),
        .buts        (buts),
        .note_onehot (note_onehot),
        .note        (note),
        .note_valid  (note_valid),
        .note_press  (note_press),
        .map_busy    (map_busy),
        .map_err     (map_err)
    );

    initial slow_clk = 1'b0;
    always #10 slow_clk = ~slow_clk;

    // Behavioural model state
    int         m_amap [8];
    int         m_shadow [8];
    int         m_left;
    logic       m_err;
    logic       m_busy;
    logic [7:0] m_hist [$];
    logic [7:0] m_onehot;
    logic       m_valid;
    logic [2:0] m_note;
    logic       m_press;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [7:0] oh;
        logic       stable;
        logic       nv;
        logic [2:0] nn;
        int         cnt [8];
        logic       legal;
        for (int n = 0; n < 8; n++) oh[n] = buts[m_amap[n]];
        m_hist.push_back(oh);
        if (m_hist.size() > MIN_HOLD + 1) void'(m_hist.pop_front());
        stable = (m_hist.size() == MIN_HOLD + 1);
        foreach (m_hist[k]) if (m_hist[k] != oh) stable = 1'b0;
        nv = stable && (oh != 8'h00);
        nn = m_note;
        if (nv) begin
            for (int i = 7; i >= 0; i--) if (oh[i]) nn = 3'(i);
        end
        m_press  = nv && (!m_valid || (nn != m_note));
        m_valid  = nv;
        m_note   = nn;
        m_onehot = oh;

        if (map_reset) begin
            for (int n = 0; n < 8; n++) m_amap[n] = n;
            m_left = 0;
            m_err  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                for (int n = 0; n < 8; n++) cnt[n] = 0;
                for (int n = 0; n < 8; n++) cnt[m_shadow[n]]++;
                legal = 1'b1;
                for (int n = 0; n < 8; n++) if (cnt[n] != 1) legal = 1'b0;
                if (legal) begin
                    for (int n = 0; n < 8; n++) m_amap[n] = m_shadow[n];
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (perm_load) begin
            for (int n = 0; n < 8; n++) m_shadow[n] = int'(perm[n]);
            m_left = 8;
        end
        m_busy = (m_left > 0);
    endtask

    // One clock: update the model, clock the DUT, compare every output.
    task automatic step();
        model_step();
        @(posedge slow_clk);
        #1;
        chk("note_onehot", 32'(note_onehot), 32'(m_onehot));
        chk("note",        32'(note),        32'(m_note));
        chk("note_valid",  32'(note_valid),  32'(m_valid));
        chk("note_press",  32'(note_press),  32'(m_press));
        chk("map_busy",    32'(map_busy),    32'(m_busy));
        chk("map_err",     32'(map_err),     32'(m_err));
    endtask

    // Pulse perm_load, then count busy cycles; optionally re-pulse mid-check.
    task automatic run_load(input int retrig_at, output int n);
        perm_load = 1'b1;
        step();
        perm_load = 1'b0;
        n = 0;
        while (map_busy && n < 20) begin
            n++;
            if (n == retrig_at) begin
                perm_load = 1'b1;
                for (int i = 0; i < 8; i++) perm[i] = 3'd3;
            end else begin
                perm_load = 1'b0;
            end
            step();
        end
        perm_load = 1'b0;
    endtask

    task automatic hold_buts(input logic [7:0] b, input int cycles);
        buts = b;
        for (int i = 0; i < cycles; i++) step();
    endtask

    typedef struct {
        logic [7:0] b;
        logic [7:0] oh;
        logic       valid;
        logic [2:0] nt;
        logic       press;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int r;
        int j;
        int t;

        tbl[0]  = '{8'h04, 8'h04, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h04, 8'h04, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{8'h04, 8'h04, 1'b1, 3'd2, 1'b1};
        tbl[3]  = '{8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
        tbl[4]  = '{8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
        tbl[5]  = '{8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[6]  = '{8'h02, 8'h02, 1'b0, 3'd2, 1'b0};
        tbl[7]  = '{8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[8]  = '{8'h02, 8'h02, 1'b0, 3'd2, 1'b0};
        tbl[9]  = '{8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[10] = '{8'h0A, 8'h0A, 1'b0, 3'd2, 1'b0};
        tbl[11] = '{8'h0A, 8'h0A, 1'b0, 3'd2, 1'b0};
        tbl[12] = '{8'h0A, 8'h0A, 1'b1, 3'd1, 1'b1};
        tbl[13] = '{8'h0A, 8'h0A, 1'b1, 3'd1, 1'b0};

        rst_n     = 1'b0;
        perm_load = 1'b0;
        map_reset = 1'b0;
        buts      = 8'h00;
        for (int i = 0; i < 8; i++) perm[i] = 3'(i);
        for (int n2 = 0; n2 < 8; n2++) m_amap[n2] = n2;
        for (int n2 = 0; n2 < 8; n2++) m_shadow[n2] = 0;
        m_left   = 0;
        m_err    = 1'b0;
        m_busy   = 1'b0;
        m_onehot = 8'h00;
        m_valid  = 1'b0;
        m_note   = 3'd0;
        m_press  = 1'b0;
        m_hist.push_back(8'h00);

        repeat (3) @(posedge slow_clk);
        #1;
        chk("rst_onehot", 32'(note_onehot), 32'h0);
        chk("rst_note",   32'(note),        32'h0);
        chk("rst_valid",  32'(note_valid),  32'h0);
        chk("rst_press",  32'(note_press),  32'h0);
        chk("rst_busy",   32'(map_busy),    32'h0);
        chk("rst_err",    32'(map_err),     32'h0);
        @(negedge slow_clk);
        rst_n = 1'b1;
        @(posedge slow_clk);
        #1;

        // Debounce table under the identity map.
        foreach (tbl[i]) begin
            buts = tbl[i].b;
            step();
            chk("tbl_onehot", 32'(note_onehot), 32'(tbl[i].oh));
            chk("tbl_valid",  32'(note_valid),  32'(tbl[i].valid));
            chk("tbl_note",   32'(note),        32'(tbl[i].nt));
            chk("tbl_press",  32'(note_press),  32'(tbl[i].press));
        end

        // Reversed map: legal, committed after 8 busy cycles.
        buts = 8'h00;
        for (int i = 0; i < 8; i++) perm[i] = 3'(7 - i);
        run_load(0, n);
        chk("rev_busy_len", 32'(n), 32'd8);
        chk("rev_err", 32'(map_err), 32'd0);
        hold_buts(8'h01, 3);
        chk("rev_onehot", 32'(note_onehot), 32'h80);
        chk("rev_note",   32'(note),        32'd7);
        chk("rev_press",  32'(note_press),  32'd1);

        // Duplicate entry: rejected, reversed map kept.
        buts = 8'h00;
        for (int i = 0; i < 7; i++) perm[i] = 3'(i);
        perm[7] = 3'd6;
        run_load(0, n);
        chk("dup_busy_len", 32'(n), 32'd8);
        chk("dup_err", 32'(map_err), 32'd1);
        hold_buts(8'h01, 3);
        chk("dup_onehot", 32'(note_onehot), 32'h80);
        chk("dup_note",   32'(note),        32'd7);

        // map_reset mid-check: aborts, identity restored, error cleared.
        buts = 8'h00;
        for (int i = 0; i < 8; i++) perm[i] = 3'(7 - i);
        perm_load = 1'b1;
        step();
        perm_load = 1'b0;
        step();
        step();
        map_reset = 1'b1;
        step();
        map_reset = 1'b0;
        chk("mr_busy", 32'(map_busy), 32'd0);
        chk("mr_err",  32'(map_err),  32'd0);
        hold_buts(8'h10, 3);
        chk("mr_onehot", 32'(note_onehot), 32'h10);
        chk("mr_note",   32'(note),        32'd4);

        // Second load during check is ignored; first snapshot (identity-like) wins.
        buts = 8'h00;
        for (int i = 0; i < 8; i++) perm[i] = 3'(i);
        perm[0] = 3'd1;
        perm[1] = 3'd0;
        run_load(3, n);
        chk("rt_busy_len", 32'(n), 32'd8);
        chk("rt_err", 32'(map_err), 32'd0);
        hold_buts(8'h01, 3);
        chk("rt_onehot", 32'(note_onehot), 32'h02);
        chk("rt_note",   32'(note),        32'd1);

        // Random stimulus against the model.
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                buts = buts;
            end else if (r < 7) begin
                buts = 8'h00;
            end else if (r < 9) begin
                buts = 8'(1 << $urandom_range(0, 7));
            end else begin
                buts = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < 8; i++) perm[i] = 3'(i);
                    for (int i = 7; i > 0; i--) begin
                        j = $urandom_range(0, i);
                        t = int'(perm[i]);
                        perm[i] = perm[j];
                        perm[j] = 3'(t);
                    end
                end else begin
                    for (int i = 0; i < 8; i++) perm[i] = 3'($urandom_range(0, 7));
                end
            end
            perm_load = ($urandom_range(0, 19) == 0);
            map_reset = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
